// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI receiver. Synchronises sclk/cs/mosi into
// the clk domain, deserialises LSB-first frames and presents each word on a
// valid/ready output register with overrun and truncated-frame pulses.
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int SKIP_EDGES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SK_W = (SKIP_EDGES > 0) ? $clog2(SKIP_EDGES + 1) : 1;

    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
    localparam logic [SK_W-1:0] SKIP_LAST = SK_W'((SKIP_EDGES > 0) ? SKIP_EDGES - 1 : 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_SHIFT   = 2'd2;
    localparam logic [1:0] ST_WAIT_CS = 2'd3;

    // synchroniser chains; bit 0 is the first stage
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    logic [1:0]        state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SK_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    // completed word handed from the FSM to the output register
    logic              offer_q, offer_d;
    logic [DATA_W-1:0] word_q, word_d;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;

    logic sclk_s, cs_s, mosi_s, fall;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign fall   = sclk_prev_q & ~sclk_s;

    // shift the asynchronous pins into the clk domain and track sclk history
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
    end

    // frame FSM: skip setup edges, shift data bits on sclk falls, detect truncation
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        skip_cnt_d  = skip_cnt_q;
        shreg_d     = shreg_q;
        offer_d     = 1'b0;
        word_d      = word_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d  = '0;
                skip_cnt_d = '0;
                shreg_d    = '0;
                if (!cs_s)
                    state_d = (SKIP_EDGES > 0) ? ST_SKIP : ST_SHIFT;
            end
            ST_SKIP: begin
                if (cs_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (fall) begin
                    skip_cnt_d = skip_cnt_q + SK_W'(1);
                    if (skip_cnt_q == SKIP_LAST)
                        state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // a last fall coinciding with cs rise still completes the word
                if (fall && bit_cnt_q == BIT_LAST) begin
                    offer_d = 1'b1;
                    word_d  = {mosi_s, shreg_q[DATA_W-2:0]};
                    state_d = ST_WAIT_CS;
                end else if (cs_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (fall) begin
                    shreg_d[bit_cnt_q] = mosi_s;
                    bit_cnt_d          = bit_cnt_q + BC_W'(1);
                end
            end
            default: begin
                if (cs_s)
                    state_d = ST_IDLE;
            end
        endcase
    end

    // output register: load on offer if empty or draining, else drop and flag
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = 1'b0;
        if (offer_q) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word_q;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            skip_cnt_q   <= '0;
            shreg_q      <= '0;
            offer_q      <= 1'b0;
            word_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            shreg_q      <= shreg_d;
            offer_q      <= offer_d;
            word_q       <= word_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives master-format frames (cs low,
// one setup sclk period, LSB-first bits launched on sclk rise, 22-clk period).
module tb_spi_slave_rx;

    localparam int DATA_W = 12;
    localparam int HALF   = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              cs = 1'b1;
    logic              mosi = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready = 1'b0;
    logic              overrun;
    logic              frame_err;
    logic              busy;

    int checks = 0;
    int passed = 0;

    int          n_overrun = 0;
    int          n_ferr    = 0;
    logic [DATA_W-1:0] acc_q[$];

    spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2), .SKIP_EDGES(1)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overrun(overrun), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // observe pulses and handshakes between active edges
    always @(negedge clk) begin
        if (overrun)   n_overrun = n_overrun + 1;
        if (frame_err) n_ferr    = n_ferr + 1;
        if (dout_valid && dout_ready) acc_q.push_back(dout);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        n_overrun = 0;
        n_ferr    = 0;
        acc_q.delete();
    endtask

    // nbits data bits; if do_rst, reset is applied instead of a clean cs rise
    task automatic send_frame(input logic [DATA_W-1:0] w, input int nbits, input bit do_rst);
        cs = 1'b0; sclk = 1'b0; mosi = 1'b0;
        wait_clk(HALF);
        sclk = 1'b1; wait_clk(HALF);
        sclk = 1'b0; wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1; mosi = w[i]; wait_clk(HALF);
            sclk = 1'b0; wait_clk(HALF);
        end
        if (do_rst) begin
            rst = 1'b1; cs = 1'b1; mosi = 1'b0;
            wait_clk(3);
            rst = 1'b0;
        end else begin
            cs = 1'b1; mosi = 1'b0;
        end
        wait_clk(HALF);
    endtask

    task automatic consume_one();
        dout_ready = 1'b1; wait_clk(1);
        dout_ready = 1'b0; wait_clk(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk = 1'($urandom); cs = 1'($urandom); mosi = 1'($urandom);
            wait_clk(1);
        end
        sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        rst = 1'b0;
        wait_clk(1);
        checks++; if (dout !== 12'h000) $display("FAIL reset_dout got %h want 000", dout); else passed++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dout_valid); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        clear_mon();
        for (int i = 0; i < 100; i++) begin
            sclk = ~sclk; mosi = 1'($urandom);
            wait_clk(5);
        end
        sclk = 1'b0; mosi = 1'b0;
        wait_clk(5);
        checks++; if (dout_valid !== 1'b0) $display("FAIL idle_toggle_valid got %b want 0", dout_valid); else passed++;
        checks++; if (busy !== 1'b0 || n_ferr != 0) $display("FAIL idle_toggle_busy got busy=%b ferr=%0d want 0/0", busy, n_ferr); else passed++;
    endtask

    task automatic test_single_frame();
        clear_mon();
        dout_ready = 1'b0;
        send_frame(12'hA5C, DATA_W, 1'b0);
        checks++; if (dout !== 12'hA5C) $display("FAIL single_dout got %h want a5c", dout); else passed++;
        checks++; if (dout_valid !== 1'b1) $display("FAIL single_valid got %b want 1", dout_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL single_busy got %b want 0", busy); else passed++;
        wait_clk(30);
        checks++; if (dout_valid !== 1'b1 || dout !== 12'hA5C) $display("FAIL single_hold got %b/%h want 1/a5c", dout_valid, dout); else passed++;
        consume_one();
        checks++; if (dout_valid !== 1'b0) $display("FAIL single_consume got %b want 0", dout_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        dout_ready = 1'b1;
        send_frame(12'h001, DATA_W, 1'b0);
        send_frame(12'h800, DATA_W, 1'b0);
        wait_clk(5);
        dout_ready = 1'b0;
        checks++; if (acc_q.size() != 2) $display("FAIL b2b_count got %0d want 2", acc_q.size()); else passed++;
        checks++; if (acc_q.size() < 1 || acc_q[0] !== 12'h001) $display("FAIL b2b_word0 got %h want 001", (acc_q.size() > 0) ? acc_q[0] : 12'hxxx); else passed++;
        checks++; if (acc_q.size() < 2 || acc_q[1] !== 12'h800) $display("FAIL b2b_word1 got %h want 800", (acc_q.size() > 1) ? acc_q[1] : 12'hxxx); else passed++;
        checks++; if (n_overrun != 0) $display("FAIL b2b_overrun got %0d want 0", n_overrun); else passed++;
        checks++; if (n_ferr != 0) $display("FAIL b2b_frame_err got %0d want 0", n_ferr); else passed++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL b2b_drained got %b want 0", dout_valid); else passed++;
    endtask

    task automatic test_overrun();
        clear_mon();
        dout_ready = 1'b0;
        send_frame(12'h123, DATA_W, 1'b0);
        send_frame(12'hFED, DATA_W, 1'b0);
        wait_clk(5);
        checks++; if (dout !== 12'h123) $display("FAIL ovr_dout got %h want 123", dout); else passed++;
        checks++; if (dout_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", dout_valid); else passed++;
        checks++; if (n_overrun != 1) $display("FAIL ovr_pulses got %0d want 1", n_overrun); else passed++;
        consume_one();
        checks++; if (dout_valid !== 1'b0) $display("FAIL ovr_consume got %b want 0", dout_valid); else passed++;
    endtask

    task automatic test_truncated();
        clear_mon();
        dout_ready = 1'b0;
        send_frame(12'hFFF, 5, 1'b0);
        wait_clk(5);
        checks++; if (n_ferr != 1) $display("FAIL trunc_frame_err got %0d want 1", n_ferr); else passed++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL trunc_valid got %b want 0", dout_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL trunc_busy got %b want 0", busy); else passed++;
        send_frame(12'h3C3, DATA_W, 1'b0);
        checks++; if (dout_valid !== 1'b1 || dout !== 12'h3C3) $display("FAIL trunc_next got %b/%h want 1/3c3", dout_valid, dout); else passed++;
        checks++; if (n_ferr != 1) $display("FAIL trunc_next_ferr got %0d want 1", n_ferr); else passed++;
        consume_one();
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        dout_ready = 1'b0;
        send_frame(12'hABC, 7, 1'b1);
        wait_clk(10);
        checks++; if (n_ferr != 0) $display("FAIL rstmid_frame_err got %0d want 0", n_ferr); else passed++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", dout_valid); else passed++;
        send_frame(12'h0F0, DATA_W, 1'b0);
        checks++; if (dout_valid !== 1'b1 || dout !== 12'h0F0) $display("FAIL rstmid_next got %b/%h want 1/0f0", dout_valid, dout); else passed++;
        checks++; if (n_ferr != 0 || n_overrun != 0) $display("FAIL rstmid_flags got ferr=%0d ovr=%0d want 0/0", n_ferr, n_overrun); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_truncated();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side stage that sits directly downstream of the team's 12-bit SPI master transmitter.
- Oversamples the incoming sclk, cs and mosi lines in the local system clock domain and deserialises each LSB-first frame into a parallel word.
- Presents each received word on a valid/ready interface.
- Flags overruns and truncated frames.

Parameters:
- DATA_W, 12, bits per frame.
- SYNC_STAGES, 2, synchroniser flops on each of sclk, cs and mosi (minimum 2).
- SKIP_EDGES, 1, sclk falling edges discarded after cs asserts (the cs-setup slot) before data bit 0.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  serial clock from the master; asynchronous to clk.
- cs  input  1  chip select, active low; asynchronous.
- mosi  input  1  serial data; the master launches it on sclk rise; asynchronous.
- dout  output  DATA_W  received word, LSB = first data bit on the wire.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: cs rose before DATA_W bits were received.
- busy  output  1  high while the state is not IDLE.

Behaviour:
- **Reset** (rst=1 at a clk edge):
  - Synchroniser chains load sclk=0, cs=1, mosi=0.
  - State goes to IDLE; bit and skip counters go to 0.
  - dout=0, dout_valid=0, overrun=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame silently, with no frame_err.
- **Synchronisation:**
  - sclk_s, cs_s and mosi_s are the last stages of their SYNC_STAGES chains.
  - fall = sclk_s previous 1 and current 0.
  - Data is sampled only on fall, i.e. mid-bit.
- **Timing requirement:** each sclk half-period must be at least SYNC_STAGES+2 clk periods. The master's half-period of 11 clk satisfies this.
- **FSM:**
  - IDLE: when cs_s=0, go to SKIP if SKIP_EDGES>0, otherwise SHIFT. Clear the counters.
  - SKIP: each fall increments skip_cnt. When skip_cnt reaches SKIP_EDGES-1 on a fall, go to SHIFT.
  - SHIFT: each fall writes shreg[bit_cnt] <= mosi_s and increments bit_cnt. On the fall with bit_cnt=DATA_W-1:
    - the completed word {mosi_s, shreg[DATA_W-2:0]} is offered to the output register;
    - go to WAIT_CS.
  - WAIT_CS: all falls are ignored. When cs_s=1, go to IDLE.
- **Truncation:** if cs_s=1 while in SKIP or SHIFT:
  - frame_err pulses for exactly 1 cycle;
  - shreg contents are discarded and nothing is offered;
  - state returns to IDLE.
- **Simultaneous cs rise and last fall:** if cs_s rises in the same cycle as the last fall, the word completes and no frame_err is raised.
- **Output register:**
  - An offered word loads dout and sets dout_valid when dout_valid=0, or when dout_valid=1 and dout_ready=1 in the same cycle. In the second case, dout_valid stays 1 and there is no overrun.
  - An offered word with dout_valid=1 and dout_ready=0 is dropped: dout is unchanged and overrun pulses for 1 cycle.
  - dout_ready=1 with no offer clears dout_valid on the next edge.
  - dout is stable while dout_valid=1 and it has not been consumed.
- **Latency:** dout_valid rises SYNC_STAGES+1 clk edges after the first clk edge at which the pin sclk is low following bit DATA_W-1's high phase.
- **Arithmetic:**
  - bit_cnt is $clog2(DATA_W) bits wide and never wraps; it is cleared in IDLE.
  - skip_cnt is $clog2(SKIP_EDGES+1) bits wide.
- **Idle-line robustness:** sclk toggling while cs=1 has no effect.

Test Plan:
- **Reset defaults:** assert rst for 3 cycles with random pins, then release with cs=1 -> all outputs 0, busy=0; 100 sclk toggles while cs high -> no dout_valid.
- **Single frame:** drive the master-format frame for 12'hA5C (cs low, 1 setup period, bits LSB-first launched on sclk rise, 22-clk sclk period), dout_ready=0 -> dout=12'hA5C, dout_valid=1 held; busy returns to 0 after cs rises.
- **Back-to-back frames:** send 12'h001 then 12'h800 with dout_ready=1 -> two accepted words in order, 12'h001 then 12'h800; no overrun, no frame_err.
- **Overrun:** send 12'h123 then 12'hFED with dout_ready=0 -> dout stays 12'h123; overrun pulses once at the second completion; then dout_ready=1 for 1 cycle -> dout_valid=0.
- **Truncated frame:** raise cs after 5 data bits -> frame_err pulses once and dout_valid stays 0; a following full frame 12'h3C3 is received correctly.
- **Reset mid-frame:** assert rst after bit 6 of a frame -> no frame_err and no dout_valid; the next complete frame 12'h0F0 is received as 12'h0F0.
